// File: rtl/wb_bram_pkg.sv
// Shared types and widths for the Wishbone BRAM slave: FSM state encoding,
// bus widths, latency counter width and a byte-lane mask helper.
package wb_bram_pkg;

    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        ACK
    } wb_bram_state_e;

    // Expands a byte-lane select into a per-bit write mask.
    function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_SW-1:0] sel);
        logic [WB_DW-1:0] m;
        m = '0;
        for (int i = 0; i < WB_SW; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_bram_if.sv
// Wishbone classic slave bundle between the management SoC and the BRAM slave.
// wbs_err_o exists only when WB_BRAM_ERR_EN is defined.
interface wb_bram_if;
    import wb_bram_pkg::*;

    // Handshake: a request is valid while wbs_cyc_i & wbs_stb_i are high; the
    // slave captures it when idle and ends it with a single-cycle wbs_ack_o (or
    // wbs_err_o). Dropping cyc/stb before the ack withdraws the request.
    logic             wbs_cyc_i;
    logic             wbs_stb_i;
    logic             wbs_we_i;
    logic [WB_SW-1:0] wbs_sel_i;
    logic [31:0]      wbs_adr_i;
    logic [WB_DW-1:0] wbs_dat_i;
    logic             wbs_ack_o;
    logic [WB_DW-1:0] wbs_dat_o;
`ifdef WB_BRAM_ERR_EN
    logic             wbs_err_o;
`endif

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
`ifdef WB_BRAM_ERR_EN
        , output wbs_err_o
`endif
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
`ifdef WB_BRAM_ERR_EN
        , input wbs_err_o
`endif
    );

endinterface

// File: rtl/wb_bram_mem.sv
// DEPTH x 32 single-port synchronous RAM with byte-lane writes.
// Read-first: a write cycle returns the word's previous contents on dout.
module wb_bram_mem
    import wb_bram_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [WB_SW-1:0]         we,
    input  logic [$clog2(DEPTH)-1:0] a,
    input  logic [WB_DW-1:0]         di,
    output logic [WB_DW-1:0]         dout
);

    logic [WB_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[a];
            if (|we) begin
                mem[a] <= (mem[a] & ~lane_mask(we)) | (di & lane_mask(we));
            end
        end
    end

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave for a user-area BRAM window with separate programmable read and
// write latencies. Define WB_BRAM_ERR_EN to answer near-miss addresses with wbs_err_o.
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
    parameter int          DEPTH     = 1024,
    parameter int          RD_DELAY  = 10,
    parameter int          WR_DELAY  = 10
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_bram_if.slave       wbs,
    output wb_bram_state_e dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] RD_D = CNT_W'(RD_DELAY);
    localparam logic [CNT_W-1:0] WR_D = CNT_W'(WR_DELAY);

    wb_bram_state_e   state_q;
    wb_bram_state_e   state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] delay;

    logic             req;
    logic             in_window;
    logic             hit;

    logic [AW-1:0]    adr_q;
    logic [WB_DW-1:0] dat_q;
    logic [WB_SW-1:0] sel_q;
    logic             we_q;
    logic [WB_DW-1:0] rd_hold_q;

    logic             mem_en;
    logic [WB_SW-1:0] mem_we;
    logic [WB_DW-1:0] mem_dout;
    logic             ack;
    logic             adr_unused;

    assign req        = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign in_window  = (wbs.wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign hit        = req & in_window;
    assign delay      = we_q ? WR_D : RD_D;
    assign adr_unused = ^wbs.wbs_adr_i[1:0];

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a withdrawn request always wins over the latency count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hit) state_d = WAIT;
            end
            WAIT: begin
                if (!req)                state_d = IDLE;
                else if (cnt_q == delay) state_d = ACCESS;
            end
            ACCESS: begin
                state_d = req ? ACK : IDLE;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_en = 1'b0;
        mem_we = '0;
        ack    = 1'b0;
        case (state_q)
            ACCESS: begin
                if (req) begin
                    mem_en = 1'b1;
                    if (we_q) mem_we = sel_q;
                end
            end
            ACK: begin
                ack = 1'b1;
            end
            default: ;
        endcase
    end

    // Request fields are frozen at accept so the master may change them freely afterwards.
    always_ff @(posedge wb_clk_i) begin
        if (state_q == IDLE && hit) begin
            adr_q <= wbs.wbs_adr_i[AW+1:2];
            dat_q <= wbs.wbs_dat_i;
            sel_q <= wbs.wbs_sel_i;
            we_q  <= wbs.wbs_we_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && hit) begin
            cnt_q <= CNT_W'(1);
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The RAM output register carries the data during ACK; rd_hold_q keeps it afterwards.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_hold_q <= '0;
        end else if (state_q == ACK && !we_q) begin
            rd_hold_q <= mem_dout;
        end
    end

    assign wbs.wbs_ack_o = ack;
    assign wbs.wbs_dat_o = (state_q == ACK && !we_q) ? mem_dout : rd_hold_q;
    assign dbg_state     = state_q;

`ifdef WB_BRAM_ERR_EN
    logic err_q;

    // Same top nibble as the window but outside it: nobody else will answer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && req && !in_window &&
                     (wbs.wbs_adr_i[31:28] == BASE_ADDR[31:28]);
        end
    end

    assign wbs.wbs_err_o = err_q;
`endif

    wb_bram_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk (wb_clk_i),
        .en  (mem_en),
        .we  (mem_we),
        .a   (adr_q),
        .di  (dat_q),
        .dout(mem_dout)
    );

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: one instance with default latencies (port 0) and one
// with RD_DELAY=3 / WR_DELAY=7 (port 1), checked against a transaction-level model.
module tb_wb_bram_ctrl;
    import wb_bram_pkg::*;

    localparam logic [31:0] BASE  = 32'h3800_0000;
    localparam int          DEPTH = 1024;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i = 1'b1;
    wb_bram_state_e dbg_a;
    wb_bram_state_e dbg_b;

    wb_bram_if bus_a ();
    wb_bram_if bus_b ();

    wb_bram_ctrl u_dut_a (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wbs      (bus_a),
        .dbg_state(dbg_a)
    );

    wb_bram_ctrl #(
        .RD_DELAY(3),
        .WR_DELAY(7)
    ) u_dut_b (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wbs      (bus_b),
        .dbg_state(dbg_b)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    int cyc_n = 0;
    always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

    logic [1:0]  ack_w;
    logic [31:0] dat_w [2];
    assign ack_w[0] = bus_a.wbs_ack_o;
    assign ack_w[1] = bus_b.wbs_ack_o;
    assign dat_w[0] = bus_a.wbs_dat_o;
    assign dat_w[1] = bus_b.wbs_dat_o;
`ifdef WB_BRAM_ERR_EN
    logic [1:0] err_w;
    assign err_w[0] = bus_a.wbs_err_o;
    assign err_w[1] = bus_b.wbs_err_o;
`endif

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [31:0] m_mem   [2][DEPTH];
    logic [31:0] exp_q_a [$];
    logic [31:0] exp_q_b [$];
    logic [31:0] exp_dat [2];
    int          ack_at  [2];
    int          err_at  [2];
    bit          pend_we [2];
    int          pend_idx[2];
    logic [31:0] pend_dat[2];
    logic [3:0]  pend_sel[2];
    int          last_ack[2];
    int          ack_cnt [2];
    int          err_cnt [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: actual %h required %h", nm, cyc_n, act, exp);
        end
    endtask

    function automatic int dly(input int p, input bit we);
        if (p == 0) return 10;
        return we ? 7 : 3;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            ack_at[p]  = -1;
            err_at[p]  = -1;
            exp_dat[p] = 32'h0;
        end
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    // Called in the cycle a request is first presented to an idle slave.
    task automatic model_accept(input int p, input bit we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel);
        if ((adr / (4 * DEPTH)) != (BASE / (4 * DEPTH))) begin
`ifdef WB_BRAM_ERR_EN
            if ((adr >> 28) == (BASE >> 28)) err_at[p] = cyc_n + 1;
`endif
            return;
        end
        ack_at[p]   = cyc_n + dly(p, we) + 2;
        pend_we[p]  = we;
        pend_idx[p] = int'((adr - BASE) / 4);
        pend_dat[p] = dat;
        pend_sel[p] = sel;
        if (!we) begin
            if (p == 0) exp_q_a.push_back(m_mem[p][pend_idx[p]]);
            else        exp_q_b.push_back(m_mem[p][pend_idx[p]]);
        end
    endtask

    task automatic model_abort(input int p);
        ack_at[p] = -1;
        if (!pend_we[p]) begin
            if (p == 0 && exp_q_a.size() > 0) void'(exp_q_a.pop_back());
            if (p == 1 && exp_q_b.size() > 0) void'(exp_q_b.pop_back());
        end
    endtask

    task automatic model_complete(input int p);
        ack_at[p] = -1;
        if (pend_we[p]) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_sel[p][b]) m_mem[p][pend_idx[p]][8*b +: 8] = pend_dat[p][8*b +: 8];
            end
        end else if (p == 0 && exp_q_a.size() > 0) begin
            exp_dat[0] = exp_q_a.pop_front();
        end else if (p == 1 && exp_q_b.size() > 0) begin
            exp_dat[1] = exp_q_b.pop_front();
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge wb_clk_i) begin
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                logic e_ack;
                e_ack = (cyc_n == ack_at[p]);
                if (e_ack) model_complete(p);
                chk($sformatf("ack%0d", p), {31'b0, ack_w[p]}, {31'b0, e_ack});
                chk($sformatf("dat_o%0d", p), dat_w[p], exp_dat[p]);
`ifdef WB_BRAM_ERR_EN
                chk($sformatf("err%0d", p), {31'b0, err_w[p]}, {31'b0, cyc_n == err_at[p]});
                if (err_w[p]) err_cnt[p]++;
`endif
                if (ack_w[p]) begin
                    last_ack[p] = cyc_n;
                    ack_cnt[p]++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive(input int p, input bit c, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (p == 0) begin
            bus_a.wbs_cyc_i = c;  bus_a.wbs_stb_i = c;  bus_a.wbs_we_i = we;
            bus_a.wbs_adr_i = adr; bus_a.wbs_dat_i = dat; bus_a.wbs_sel_i = sel;
        end else begin
            bus_b.wbs_cyc_i = c;  bus_b.wbs_stb_i = c;  bus_b.wbs_we_i = we;
            bus_b.wbs_adr_i = adr; bus_b.wbs_dat_i = dat; bus_b.wbs_sel_i = sel;
        end
    endtask

    task automatic release_bus(input int p);
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Presents a request and returns in the cycle after its ack, bus still driven.
    task automatic xfer(input int p, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, output int acc);
        drive(p, 1'b1, we, adr, dat, sel);
        acc = cyc_n;
        model_accept(p, we, adr, dat, sel);
        tick(dly(p, we) + 3);
    endtask

    // Presents a request and withdraws it n cycles later.
    task automatic aborted(input int p, input bit we, input logic [31:0] adr,
                           input logic [31:0] dat, input int n);
        drive(p, 1'b1, we, adr, dat, 4'hF);
        model_accept(p, we, adr, dat, 4'hF);
        tick(n);
        release_bus(p);
        model_abort(p);
        tick(14);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int a1;
        int n;
`ifdef WB_BRAM_ERR_EN
        int e;
`endif
        for (int p = 0; p < 2; p++) begin
            last_ack[p] = -1;
            ack_cnt[p]  = 0;
            err_cnt[p]  = 0;
        end
        model_reset();
        release_bus(0);
        release_bus(1);
        wb_rst_i = 1'b1;
        tick(3);
        wb_rst_i = 1'b0;
        chk_en = 1;
        chk("rst_state_a", dbg_a, IDLE);
        chk("rst_state_b", dbg_b, IDLE);
        chk("rst_ack_a", {31'b0, ack_w[0]}, 32'h0);
        chk("rst_dat_a", dat_w[0], 32'h0);

        // Default latency D=10: ack 12 cycles after accept
        xfer(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, acc); release_bus(0);
        chk("wr_lat_d10", last_ack[0] - acc, 12);
        xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, acc); release_bus(0);
        chk("rd_lat_d10", last_ack[0] - acc, 12);
        chk("rd_data", dat_w[0], 32'hDEAD_BEEF);

        // Byte lane write, read back through an unaligned byte address
        xfer(0, 1'b1, BASE + 32'h10, 32'h0000_AB00, 4'b0010, acc); release_bus(0);
        xfer(0, 1'b0, BASE + 32'h13, 32'h0, 4'hF, acc); release_bus(0);
        chk("byte_wr", dat_w[0], 32'hDEAD_ABEF);

        // sel=0 write: handshake completes, nothing changes
        xfer(0, 1'b1, BASE + 32'h10, 32'h1234_5678, 4'h0, acc); release_bus(0);
        chk("sel0_lat", last_ack[0] - acc, 12);
        xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, acc); release_bus(0);
        chk("sel0_keep", dat_w[0], 32'hDEAD_ABEF);

        // Aborts: cyc dropped in WAIT (cycle 4) and in ACCESS (cycle 11)
        xfer(0, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, acc); release_bus(0);
        n = ack_cnt[0];
        aborted(0, 1'b1, BASE + 32'h20, 32'h1111_1111, 4);
        aborted(0, 1'b1, BASE + 32'h20, 32'h2222_2222, 11);
        chk("abort_no_ack", ack_cnt[0] - n, 0);
        xfer(0, 1'b0, BASE + 32'h20, 32'h0, 4'hF, acc); release_bus(0);
        chk("abort_keep", dat_w[0], 32'hCAFE_F00D);
        aborted(0, 1'b0, BASE + 32'h10, 32'h0, 11);
        chk("rd_abort_hold", dat_w[0], 32'hCAFE_F00D);

        // Reset while a write waits: dropped, outputs cleared, fresh request works
        drive(0, 1'b1, 1'b1, BASE + 32'h20, 32'h55AA_55AA, 4'hF);
        model_accept(0, 1'b1, BASE + 32'h20, 32'h55AA_55AA, 4'hF);
        tick(3);
        wb_rst_i = 1'b1;
        release_bus(0);
        tick(1);
        wb_rst_i = 1'b0;
        model_reset();
        chk("wait_rst_state", dbg_a, IDLE);
        chk("wait_rst_dat", dat_w[0], 32'h0);
        xfer(0, 1'b0, BASE + 32'h20, 32'h0, 4'hF, acc); release_bus(0);
        chk("post_rst_lat", last_ack[0] - acc, 12);
        chk("post_rst_data", dat_w[0], 32'hCAFE_F00D);

        // RD_DELAY=3 / WR_DELAY=7 instance
        xfer(1, 1'b1, BASE + 32'h40, 32'h0102_0304, 4'hF, acc); release_bus(1);
        chk("wr_lat_d7", last_ack[1] - acc, 9);
        xfer(1, 1'b1, BASE + 32'h44, 32'hA5A5_0F0F, 4'hF, acc); release_bus(1);
        xfer(1, 1'b0, BASE + 32'h40, 32'h0, 4'hF, acc);
        chk("rd_lat_d3", last_ack[1] - acc, 5);
        a1 = last_ack[1];
        xfer(1, 1'b0, BASE + 32'h44, 32'h0, 4'hF, acc); release_bus(1);
        chk("b2b_gap", last_ack[1] - a1, 6);
        chk("b2b_data", dat_w[1], 32'hA5A5_0F0F);
        xfer(1, 1'b1, BASE + 32'h48, 32'h0BAD_F00D, 4'hF, acc);
        xfer(1, 1'b0, BASE + 32'h48, 32'h0, 4'hF, acc); release_bus(1);
        chk("wr_rd_b2b", dat_w[1], 32'h0BAD_F00D);

        // Just past the window, then a foreign region
        n = ack_cnt[1];
`ifdef WB_BRAM_ERR_EN
        e = err_cnt[1];
        drive(1, 1'b1, 1'b0, BASE + 32'h1000, 32'h0, 4'hF);
        model_accept(1, 1'b0, BASE + 32'h1000, 32'h0, 4'hF);
        tick(1);
        release_bus(1);
        tick(20);
        chk("err_pulses", err_cnt[1] - e, 1);
`else
        drive(1, 1'b1, 1'b0, BASE + 32'h1000, 32'h0, 4'hF);
        model_accept(1, 1'b0, BASE + 32'h1000, 32'h0, 4'hF);
        tick(20);
        release_bus(1);
        tick(2);
`endif
        drive(1, 1'b1, 1'b1, 32'h2000_0000, 32'h0, 4'hF);
        model_accept(1, 1'b1, 32'h2000_0000, 32'h0, 4'hF);
        tick(3);
        release_bus(1);
        tick(3);
        chk("miss_no_ack", ack_cnt[1] - n, 0);
        chk("end_state_b", dbg_b, IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
